bus_arbiter_rr: RTL and testbench
=================================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NR_OF_MASTERS, default 4, number of bus masters (2..8).
REQ-002 SHALL have parameter BEGIN_TIMEOUT, default 16, cycles a granted master may take to assert beginTransaction.
REQ-003 SHALL have parameter ACTIVE_TIMEOUT, default 1024, cycles a transaction may stay open before forced termination.
REQ-004 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port busRequests, input, NR_OF_MASTERS, per-master requestBus.
REQ-007 SHALL have port busGrants, output, NR_OF_MASTERS, registered one-hot grant (at most one bit set).
REQ-008 SHALL have port beginTransactionIn, input, 1, shared-bus begin strobe.
REQ-009 SHALL have port endTransactionIn, input, 1, shared-bus end strobe.
REQ-010 SHALL have port busErrorIn, input, 1, slave-signalled bus error.
REQ-011 SHALL have port endTransactionOut, output, 1, arbiter-driven end strobe on forced termination.
REQ-012 SHALL have port busErrorOut, output, 1, arbiter-driven error to all masters on timeout.
REQ-013 SHALL have port activeMaster, output, 3, index of granted master; 0 when none.
REQ-014 SHALL have port busBusy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, GRANTED, ACTIVE, ABORT.
REQ-016 IDLE: if any busRequests bit set, select winner, go GRANTED; busGrants winner bit high in the next cycle (1-cycle grant latency).
REQ-017 Winner SHALL be the first requesting index strictly after lastGranted, searching upward and wrapping NR_OF_MASTERS-1 -> 0; lastGranted updates only on grant.
REQ-018 GRANTED: beginTransactionIn -> ACTIVE; requester drops request before begin -> IDLE; wait counter reaching BEGIN_TIMEOUT -> IDLE; grant removed in cycle after exit, no error issued.
REQ-019 ACTIVE: endTransactionIn -> IDLE; grant low in the following cycle; watchdog counter cleared on entry, incremented each ACTIVE cycle.
REQ-020 ACTIVE: watchdog == ACTIVE_TIMEOUT-1 without endTransactionIn -> ABORT.
REQ-021 ABORT: busErrorOut and endTransactionOut high for exactly one cycle, grant low, then IDLE.
REQ-022 busErrorIn in ACTIVE SHALL not alter state; transaction still closes via endTransactionIn or watchdog.
REQ-023 endTransactionIn and watchdog expiry in same cycle: end wins, no ABORT.
REQ-024 beginTransactionIn or endTransactionIn while IDLE SHALL be ignored.
REQ-025 Counters SHALL be sized clog2 of their timeout parameter +1 bits and never wrap.
REQ-026 A master re-requesting immediately after its own transaction SHALL be served only after all other pending requesters (fairness).
REQ-027 No combinational path from busRequests to busGrants.

Reset
REQ-028 On reset: state IDLE, busGrants 0, busErrorOut 0, endTransactionOut 0, activeMaster 0, busBusy 0, counters 0, lastGranted NR_OF_MASTERS-1 (so master 0 wins first).
REQ-029 Reset mid-transaction SHALL drop grant in the next cycle without issuing endTransactionOut.

Structure
REQ-030 Shared package SHALL hold state encoding and default timeout constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_priority_select (requests, lastGranted -> one-hot winner, index, valid), purely combinational.

Verification
REQ-032 Reset, busRequests=4'b0001 -> busGrants=4'b0001 one cycle later, activeMaster=0.
REQ-033 busRequests=4'b1111 held, each master begin/end after 3 cycles -> grant order 0,1,2,3,0.
REQ-034 Grant master 2, no begin for 16 cycles -> grant drops, busErrorOut stays 0, next requester granted.
REQ-035 ACTIVE_TIMEOUT=8, begin without end -> after 8 ACTIVE cycles busErrorOut=1 and endTransactionOut=1 for one cycle, then IDLE.
REQ-036 end and watchdog expiry same cycle -> IDLE, busErrorOut=0; reset asserted in ACTIVE -> busGrants=0 next cycle, endTransactionOut=0.

Source files
------------

// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arbiter_rr_pkg
//   Shared definitions for the round-robin bus arbiter: FSM state encoding,
//   master index width and default timeout values.
package bus_arbiter_rr_pkg;

   // Master index width; covers up to 8 masters.
   localparam int IDX_W = 3;

   localparam int DEF_BEGIN_TIMEOUT  = 16;
   localparam int DEF_ACTIVE_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_ACTIVE  = 2'd2,
      ST_ABORT   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// rr_priority_select
//   Purely combinational round-robin picker. Finds the first requesting
//   index strictly after last_granted, searching upward and wrapping at
//   NR_OF_MASTERS-1 -> 0.
//   Ports:
//     requests     : per-master request vector
//     last_granted : index of the most recently granted master
//     winner       : one-hot winner (zero when no request)
//     index        : winner index (zero when no request)
//     valid        : at least one request present
module rr_priority_select
   import bus_arbiter_rr_pkg::*;
#(
   parameter int NR_OF_MASTERS = 4
) (
   input  logic [NR_OF_MASTERS-1:0] requests,
   input  logic [IDX_W-1:0]         last_granted,
   output logic [NR_OF_MASTERS-1:0] winner,
   output logic [IDX_W-1:0]         index,
   output logic                     valid
);

   // Offset 1 is the highest-priority slot, offset NR_OF_MASTERS (i.e. the
   // last granted master itself) the lowest. Candidate i sits at offset off
   // when last_granted+off equals i, or i+NR_OF_MASTERS after wrapping.
   always_comb begin
      winner = '0;
      index  = '0;
      valid  = 1'b0;
      for (int off = 1; off <= NR_OF_MASTERS; off++) begin
         for (int i = 0; i < NR_OF_MASTERS; i++) begin
            if (!valid && requests[i] &&
                ((int'(last_granted) + off == i) ||
                 (int'(last_granted) + off == i + NR_OF_MASTERS))) begin
               valid     = 1'b1;
               winner[i] = 1'b1;
               index     = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr
//   Round-robin arbiter for a shared bus with begin-timeout and active
//   watchdog. A grant is issued one cycle after a request is seen in IDLE.
//   A granted master that never begins loses the grant silently; an open
//   transaction that outlives the watchdog is killed with a one-cycle
//   busErrorOut + endTransactionOut pulse.
//   Ports:
//     clock, reset        : rising-edge clock, synchronous active-high reset
//     busRequests         : per-master request
//     busGrants           : registered one-hot grant
//     beginTransactionIn  : shared begin strobe
//     endTransactionIn    : shared end strobe
//     busErrorIn          : slave error (observed, does not steer the FSM)
//     endTransactionOut   : forced end strobe on watchdog abort
//     busErrorOut         : error broadcast on watchdog abort
//     activeMaster        : index of granted master, 0 when none
//     busBusy             : high whenever the FSM is not IDLE
module bus_arbiter_rr
   import bus_arbiter_rr_pkg::*;
#(
   parameter int NR_OF_MASTERS  = 4,
   parameter int BEGIN_TIMEOUT  = DEF_BEGIN_TIMEOUT,
   parameter int ACTIVE_TIMEOUT = DEF_ACTIVE_TIMEOUT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NR_OF_MASTERS-1:0] busRequests,
   output logic [NR_OF_MASTERS-1:0] busGrants,
   input  logic                     beginTransactionIn,
   input  logic                     endTransactionIn,
   input  logic                     busErrorIn,
   output logic                     endTransactionOut,
   output logic                     busErrorOut,
   output logic [IDX_W-1:0]         activeMaster,
   output logic                     busBusy
);

   localparam int WAIT_W = $clog2(BEGIN_TIMEOUT) + 1;
   localparam int WDOG_W = $clog2(ACTIVE_TIMEOUT) + 1;

   arb_state_e               state_q, state_d;
   logic [NR_OF_MASTERS-1:0] grants_q, grants_d;
   logic [IDX_W-1:0]         active_q, active_d;
   logic [IDX_W-1:0]         last_q, last_d;
   logic [WAIT_W-1:0]        wait_q, wait_d;
   logic [WDOG_W-1:0]        wdog_q, wdog_d;
   logic                     err_q, err_d;
   logic                     endo_q, endo_d;

   logic [NR_OF_MASTERS-1:0] sel_winner;
   logic [IDX_W-1:0]         sel_index;
   logic                     sel_valid;

   // A slave error never changes arbitration; the transaction still closes
   // through the end strobe or the watchdog.
   logic unused_bus_error;
   assign unused_bus_error = busErrorIn;

   rr_priority_select #(
      .NR_OF_MASTERS(NR_OF_MASTERS)
   ) u_select (
      .requests    (busRequests),
      .last_granted(last_q),
      .winner      (sel_winner),
      .index       (sel_index),
      .valid       (sel_valid)
   );

   always_comb begin
      state_d  = state_q;
      grants_d = grants_q;
      active_d = active_q;
      last_d   = last_q;
      wait_d   = wait_q;
      wdog_d   = wdog_q;
      err_d    = 1'b0;
      endo_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (sel_valid) begin
               state_d  = ST_GRANTED;
               grants_d = sel_winner;
               active_d = sel_index;
               last_d   = sel_index;
               wait_d   = '0;
            end
         end
         ST_GRANTED: begin
            // grants_q is one-hot, so masking picks the holder's request.
            if (beginTransactionIn) begin
               state_d = ST_ACTIVE;
               wdog_d  = '0;
            end else if ((busRequests & grants_q) == '0 ||
                         wait_q == WAIT_W'(BEGIN_TIMEOUT - 1)) begin
               state_d  = ST_IDLE;
               grants_d = '0;
               active_d = '0;
            end else if (wait_q != '1) begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_ACTIVE: begin
            // End strobe takes precedence over a simultaneous expiry.
            if (endTransactionIn) begin
               state_d  = ST_IDLE;
               grants_d = '0;
               active_d = '0;
            end else if (wdog_q == WDOG_W'(ACTIVE_TIMEOUT - 1)) begin
               state_d  = ST_ABORT;
               grants_d = '0;
               active_d = '0;
               err_d    = 1'b1;
               endo_d   = 1'b1;
            end else if (wdog_q != '1) begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         grants_q <= '0;
         active_q <= '0;
         last_q   <= IDX_W'(NR_OF_MASTERS - 1);
         wait_q   <= '0;
         wdog_q   <= '0;
         err_q    <= 1'b0;
         endo_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grants_q <= grants_d;
         active_q <= active_d;
         last_q   <= last_d;
         wait_q   <= wait_d;
         wdog_q   <= wdog_d;
         err_q    <= err_d;
         endo_q   <= endo_d;
      end
   end

   assign busGrants         = grants_q;
   assign activeMaster      = active_q;
   assign busErrorOut       = err_q;
   assign endTransactionOut = endo_q;
   assign busBusy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;
   localparam int N = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] busRequests;
   logic [N-1:0] busGrants;
   logic         beginTransactionIn, endTransactionIn, busErrorIn;
   logic         endTransactionOut, busErrorOut;
   logic [2:0]   activeMaster;
   logic         busBusy;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   bus_arbiter_rr #(
      .NR_OF_MASTERS (N),
      .BEGIN_TIMEOUT (16),
      .ACTIVE_TIMEOUT(8)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .busRequests       (busRequests),
      .busGrants         (busGrants),
      .beginTransactionIn(beginTransactionIn),
      .endTransactionIn  (endTransactionIn),
      .busErrorIn        (busErrorIn),
      .endTransactionOut (endTransactionOut),
      .busErrorOut       (busErrorOut),
      .activeMaster      (activeMaster),
      .busBusy           (busBusy)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; busRequests = '0;
      beginTransactionIn = 1'b0; endTransactionIn = 1'b0; busErrorIn = 1'b0;
      tick; tick;
      reset = 1'b0;
   endtask

   task automatic wait_grant(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick;
         if (busGrants != '0) got = 1'b1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; busRequests = 4'b1111;
      beginTransactionIn = 1'b0; endTransactionIn = 1'b0; busErrorIn = 1'b0;
      tick; tick;
      tests_run++;
      if (busGrants !== 4'b0000) begin tests_failed++;
         $display("FAIL reset_grants: got %b want 0000", busGrants); end
      tests_run++;
      if ({busBusy, busErrorOut, endTransactionOut} !== 3'b000) begin tests_failed++;
         $display("FAIL reset_flags: busy/err/end got %b want 000",
                  {busBusy, busErrorOut, endTransactionOut}); end
      tests_run++;
      if (activeMaster !== 3'd0) begin tests_failed++;
         $display("FAIL reset_active: got %0d want 0", activeMaster); end
      reset = 1'b0; busRequests = '0;
      tick;
   endtask

   task automatic test_idle_ignore;
      do_reset;
      beginTransactionIn = 1'b1; endTransactionIn = 1'b1;
      tick;
      beginTransactionIn = 1'b0; endTransactionIn = 1'b0;
      tests_run++;
      if ({busBusy, busGrants, endTransactionOut} !== 6'b0) begin tests_failed++;
         $display("FAIL idle_ignore: busy=%b grants=%b endo=%b want 0/0000/0",
                  busBusy, busGrants, endTransactionOut); end
   endtask

   task automatic test_single_grant;
      do_reset;
      busRequests = 4'b0001;
      tick;
      tests_run++;
      if (busGrants !== 4'b0001 || activeMaster !== 3'd0 || busBusy !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_grant: grants=%b active=%0d busy=%b want 0001/0/1",
                  busGrants, activeMaster, busBusy); end
      beginTransactionIn = 1'b1;
      tick;
      beginTransactionIn = 1'b0; busRequests = '0; endTransactionIn = 1'b1;
      tick;
      endTransactionIn = 1'b0;
      tests_run++;
      if (busGrants !== 4'b0000 || busBusy !== 1'b0 || endTransactionOut !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_end: grants=%b busy=%b endo=%b want 0000/0/0",
                  busGrants, busBusy, endTransactionOut); end
   endtask

   task automatic test_rotation;
      bit got;
      int exp;
      do_reset;
      busRequests = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp = k % N;
         wait_grant(got);
         tests_run++;
         if (!got || busGrants !== 4'(1 << exp) || activeMaster !== 3'(exp)) begin
            tests_failed++;
            $display("FAIL rotation_%0d: grants=%b active=%0d want %b/%0d",
                     k, busGrants, activeMaster, 4'(1 << exp), exp); end
         tick; tick;
         beginTransactionIn = 1'b1; tick; beginTransactionIn = 1'b0;
         tick; tick; tick;
         endTransactionIn = 1'b1; tick; endTransactionIn = 1'b0;
      end
      busRequests = '0;
      tick; tick;
   endtask

   task automatic test_begin_timeout;
      int err_seen = 0;
      int drop_seen = 0;
      do_reset;
      busRequests = 4'b0100;
      tick;
      tests_run++;
      if (busGrants !== 4'b0100 || activeMaster !== 3'd2) begin tests_failed++;
         $display("FAIL tmo_grant2: grants=%b active=%0d want 0100/2",
                  busGrants, activeMaster); end
      busRequests = 4'b0101;
      for (int i = 0; i < 15; i++) begin
         tick;
         if (busErrorOut) err_seen++;
         if (busGrants !== 4'b0100) drop_seen++;
      end
      tests_run++;
      if (drop_seen != 0) begin tests_failed++;
         $display("FAIL tmo_hold: grant lost on %0d of 15 cycles, want 0", drop_seen); end
      tick;
      tests_run++;
      if (busGrants !== 4'b0000 || busErrorOut !== 1'b0 || err_seen != 0) begin
         tests_failed++;
         $display("FAIL tmo_drop: grants=%b err=%b err_cycles=%0d want 0000/0/0",
                  busGrants, busErrorOut, err_seen); end
      tick;
      tests_run++;
      if (busGrants !== 4'b0001 || activeMaster !== 3'd0) begin tests_failed++;
         $display("FAIL tmo_next: grants=%b active=%0d want 0001/0",
                  busGrants, activeMaster); end
      busRequests = '0;
      tick;
      tests_run++;
      if (busGrants !== 4'b0000 || busBusy !== 1'b0) begin tests_failed++;
         $display("FAIL req_drop: grants=%b busy=%b want 0000/0", busGrants, busBusy); end
   endtask

   task automatic test_watchdog;
      int early = 0;
      do_reset;
      busRequests = 4'b0001;
      tick;
      beginTransactionIn = 1'b1; tick; beginTransactionIn = 1'b0;
      busErrorIn = 1'b1; tick; busErrorIn = 1'b0;
      tests_run++;
      if (busGrants !== 4'b0001 || busBusy !== 1'b1 || busErrorOut !== 1'b0) begin
         tests_failed++;
         $display("FAIL bus_error_in: grants=%b busy=%b err=%b want 0001/1/0",
                  busGrants, busBusy, busErrorOut); end
      for (int i = 0; i < 6; i++) begin
         tick;
         if (busErrorOut || endTransactionOut || busGrants !== 4'b0001) early++;
      end
      tests_run++;
      if (early != 0) begin tests_failed++;
         $display("FAIL wdog_early: %0d premature cycles, want 0", early); end
      tick;
      tests_run++;
      if (busErrorOut !== 1'b1 || endTransactionOut !== 1'b1 || busGrants !== 4'b0000) begin
         tests_failed++;
         $display("FAIL wdog_abort: err=%b endo=%b grants=%b want 1/1/0000",
                  busErrorOut, endTransactionOut, busGrants); end
      busRequests = '0;
      tick;
      tests_run++;
      if ({busErrorOut, endTransactionOut, busBusy} !== 3'b000) begin tests_failed++;
         $display("FAIL wdog_idle: err/endo/busy got %b want 000",
                  {busErrorOut, endTransactionOut, busBusy}); end
   endtask

   task automatic test_end_vs_watchdog;
      do_reset;
      busRequests = 4'b0001;
      tick;
      beginTransactionIn = 1'b1; tick; beginTransactionIn = 1'b0;
      busRequests = '0;
      repeat (7) tick;
      endTransactionIn = 1'b1; tick; endTransactionIn = 1'b0;
      tests_run++;
      if ({busErrorOut, endTransactionOut, busBusy} !== 3'b000 || busGrants !== 4'b0000) begin
         tests_failed++;
         $display("FAIL end_wins: err/endo/busy=%b grants=%b want 000/0000",
                  {busErrorOut, endTransactionOut, busBusy}, busGrants); end
   endtask

   task automatic test_reset_active;
      do_reset;
      busRequests = 4'b0010;
      tick;
      beginTransactionIn = 1'b1; tick; beginTransactionIn = 1'b0;
      reset = 1'b1; tick; reset = 1'b0; busRequests = '0;
      tests_run++;
      if (busGrants !== 4'b0000 || endTransactionOut !== 1'b0 || busBusy !== 1'b0 ||
          activeMaster !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_active: grants=%b endo=%b busy=%b active=%0d want 0000/0/0/0",
                  busGrants, endTransactionOut, busBusy, activeMaster); end
   endtask

   task automatic test_fairness;
      do_reset;
      busRequests = 4'b0101;
      tick;
      beginTransactionIn = 1'b1; tick; beginTransactionIn = 1'b0;
      endTransactionIn = 1'b1; tick; endTransactionIn = 1'b0;
      tick;
      tests_run++;
      if (busGrants !== 4'b0100 || activeMaster !== 3'd2) begin tests_failed++;
         $display("FAIL fairness: grants=%b active=%0d want 0100/2",
                  busGrants, activeMaster); end
      busRequests = '0;
      tick;
   endtask

   initial begin
      test_reset;
      test_idle_ignore;
      test_single_grant;
      test_rotation;
      test_begin_timeout;
      test_watchdog;
      test_end_vs_watchdog;
      test_reset_active;
      test_fairness;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1);
   end

endmodule
